// File: rtl/parking_gate_controller.sv
// Parking-lot gate controller: PIN check on keypad strobe, gate open/close,
// latched wrong-PIN alarm and latched tailgating alarm.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | gate closed, no vehicle waiting, attempt count cleared
// WAIT_PIN    | vehicle on entry loop, waiting for keypad submissions
// OPEN        | correct PIN accepted, gate open until the vehicle leaves
// PIN_ALARM   | too many consecutive wrong PINs, locked until reset
// BLOCK_ALARM | tailgating seen while open, cleared by a correct PIN
module parking_gate_controller #(
  parameter logic [15:0] PASSWORD     = 16'h5990,
  parameter int          MAX_ATTEMPTS = 3,
  parameter int          CNT_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vehicle_arrival,
  input  logic             vehicle_left,
  input  logic [15:0]      code,
  input  logic             code_ack,
  output logic             gate_open,
  output logic             gate_close,
  output logic             wrong_pin,
  output logic             pin_alarm,
  output logic             block_alarm,
  output logic [CNT_W-1:0] attempts
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_PIN    = 3'd1,
    OPEN        = 3'd2,
    PIN_ALARM   = 3'd3,
    BLOCK_ALARM = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ATTEMPTS);

  state_t           state, state_nx;
  logic             ack_q;
  logic             ack_rise;
  logic             code_ok;
  logic [CNT_W-1:0] attempts_nx;
  logic [CNT_W-1:0] attempts_inc;
  logic             wrong_nx;

  assign ack_rise     = code_ack & ~ack_q;
  assign code_ok      = (code == PASSWORD);
  assign attempts_inc = attempts + 1'b1;

  // Keypad strobe edge detector; held-high strobe counts once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_q <= 1'b0;
    else      ack_q <= code_ack;
  end

  // State, counter and registered output decodes (taken from next state so
  // every response is visible right after the edge that sampled its cause).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      attempts    <= '0;
      wrong_pin   <= 1'b0;
      gate_open   <= 1'b0;
      gate_close  <= 1'b1;
      pin_alarm   <= 1'b0;
      block_alarm <= 1'b0;
    end else begin
      state       <= state_nx;
      attempts    <= attempts_nx;
      wrong_pin   <= wrong_nx;
      gate_open   <= (state_nx == OPEN);
      gate_close  <= (state_nx != OPEN);
      pin_alarm   <= (state_nx == PIN_ALARM);
      block_alarm <= (state_nx == BLOCK_ALARM);
    end
  end

  // Next-state, attempt counter and wrong-PIN pulse.
  always_comb begin
    state_nx    = state;
    attempts_nx = attempts;
    wrong_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        attempts_nx = '0;
        if (vehicle_arrival) state_nx = WAIT_PIN;
      end
      WAIT_PIN: begin
        if (ack_rise) begin
          if (code_ok) begin
            state_nx    = OPEN;
            attempts_nx = '0;
          end else if (attempts < MAX_CNT) begin
            // Guarded so the count can never pass MAX_ATTEMPTS or wrap.
            wrong_nx    = 1'b1;
            attempts_nx = attempts_inc;
            if (attempts_inc == MAX_CNT) state_nx = PIN_ALARM;
          end
        end else if (!vehicle_arrival) begin
          state_nx    = IDLE;
          attempts_nx = '0;
        end
      end
      OPEN: begin
        if (vehicle_arrival && vehicle_left) state_nx = BLOCK_ALARM;
        else if (vehicle_left)              state_nx = IDLE;
      end
      PIN_ALARM: begin
        attempts_nx = MAX_CNT;
      end
      BLOCK_ALARM: begin
        if (ack_rise && code_ok) state_nx = IDLE;
      end
      default: begin
        state_nx    = IDLE;
        attempts_nx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller. Inputs change on the falling
// edge, outputs are sampled on the falling edge after the sampling rise.
module tb_parking_gate_controller;

  logic        clk;
  logic        rst;
  logic        vehicle_arrival;
  logic        vehicle_left;
  logic [15:0] code;
  logic        code_ack;
  logic        gate_open;
  logic        gate_close;
  logic        wrong_pin;
  logic        pin_alarm;
  logic        block_alarm;
  logic [1:0]  attempts;

  int checks;
  int failures;
  int pulses;

  parking_gate_controller dut (
    .clk             (clk),
    .rst             (rst),
    .vehicle_arrival (vehicle_arrival),
    .vehicle_left    (vehicle_left),
    .code            (code),
    .code_ack        (code_ack),
    .gate_open       (gate_open),
    .gate_close      (gate_close),
    .wrong_pin       (wrong_pin),
    .pin_alarm       (pin_alarm),
    .block_alarm     (block_alarm),
    .attempts        (attempts)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a code with a rising strobe; outputs are sampled one edge later.
  task automatic submit(input logic [15:0] c);
    code     = c;
    code_ack = 1'b1;
    step(1);
  endtask

  task automatic drop_ack();
    code_ack = 1'b0;
    step(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_open"},  gate_open,   1'b0);
    check({tag, "_close"}, gate_close,  1'b1);
    check({tag, "_wrong"}, wrong_pin,   1'b0);
    check({tag, "_palm"},  pin_alarm,   1'b0);
    check({tag, "_balm"},  block_alarm, 1'b0);
    check({tag, "_att"},   attempts,    2'd0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    vehicle_arrival = 1'b0;
    vehicle_left    = 1'b0;
    code            = 16'h0000;
    code_ack        = 1'b0;
    step(2);
    check_reset_values("rst0");
    rst = 1'b1;

    // Correct PIN, then leave.
    vehicle_arrival = 1'b1;
    step(1);
    check("wait_closed", gate_open, 1'b0);
    submit(16'h5990);
    check("ok_open", gate_open, 1'b1);
    check("ok_close_n", gate_close, 1'b0);
    check("ok_att", attempts, 2'd0);
    code_ack        = 1'b0;
    vehicle_arrival = 1'b0;
    vehicle_left    = 1'b1;
    step(1);
    check("leave_open", gate_open, 1'b0);
    check("leave_close", gate_close, 1'b1);
    vehicle_left = 1'b0;
    step(1);

    // Two wrong PINs, then the vehicle backs off.
    vehicle_arrival = 1'b1;
    step(1);
    submit(16'h1234);
    check("w1_pulse", wrong_pin, 1'b1);
    check("w1_att", attempts, 2'd1);
    drop_ack();
    check("w1_pulse_end", wrong_pin, 1'b0);
    submit(16'h3145);
    check("w2_pulse", wrong_pin, 1'b1);
    check("w2_att", attempts, 2'd2);
    check("w2_noalarm", pin_alarm, 1'b0);
    drop_ack();
    vehicle_arrival = 1'b0;
    step(1);
    check("backoff_att", attempts, 2'd0);
    check("backoff_closed", gate_close, 1'b1);

    // Three wrong PINs raise the latched alarm.
    vehicle_arrival = 1'b1;
    step(1);
    submit(16'h1234);
    drop_ack();
    submit(16'h3145);
    drop_ack();
    submit(16'h4321);
    check("w3_pulse", wrong_pin, 1'b1);
    check("w3_alarm", pin_alarm, 1'b1);
    check("w3_att", attempts, 2'd3);
    drop_ack();
    check("alarm_pulse_end", wrong_pin, 1'b0);
    submit(16'h5990);
    check("alarm_ignore_open", gate_open, 1'b0);
    check("alarm_hold", pin_alarm, 1'b1);
    check("alarm_att_hold", attempts, 2'd3);
    vehicle_arrival = 1'b0;
    step(3);
    check("alarm_latched", pin_alarm, 1'b1);
    #2 rst = 1'b0;
    #1 check_reset_values("rst_palm");
    code_ack = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);

    // Tailgating while open.
    vehicle_arrival = 1'b1;
    step(1);
    submit(16'h5990);
    check("tg_open", gate_open, 1'b1);
    drop_ack();
    check("tg_still_open", gate_open, 1'b1);
    vehicle_left = 1'b1;
    step(1);
    check("tg_balm", block_alarm, 1'b1);
    check("tg_gate_shut", gate_open, 1'b0);
    check("tg_close", gate_close, 1'b1);
    vehicle_arrival = 1'b0;
    vehicle_left    = 1'b0;
    submit(16'h1234);
    check("tg_no_pulse", wrong_pin, 1'b0);
    check("tg_no_count", attempts, 2'd0);
    check("tg_balm_hold", block_alarm, 1'b1);
    drop_ack();
    submit(16'h5990);
    check("tg_cleared", block_alarm, 1'b0);
    check("tg_idle_closed", gate_open, 1'b0);
    drop_ack();

    // Held strobe counts once; code changes while held are ignored.
    vehicle_arrival = 1'b1;
    step(1);
    pulses   = 0;
    code     = 16'h0bad;
    code_ack = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (wrong_pin) pulses++;
      if (i == 5) code = 16'h5990;
    end
    check("held_pulses", pulses, 1);
    check("held_att", attempts, 2'd1);
    check("held_not_open", gate_open, 1'b0);
    drop_ack();
    vehicle_arrival = 1'b0;
    step(1);
    check("held_idle_att", attempts, 2'd0);

    // Strobe wins over arrival dropping; async reset from OPEN.
    vehicle_arrival = 1'b1;
    step(1);
    vehicle_arrival = 1'b0;
    submit(16'h5990);
    check("simul_open", gate_open, 1'b1);
    drop_ack();
    check("simul_hold", gate_open, 1'b1);
    #3 rst = 1'b0;
    #1 check("arst_open", gate_open, 1'b0);
    check("arst_close", gate_close, 1'b1);
    step(1);
    rst = 1'b1;
    step(2);
    check_reset_values("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
